// File: rtl/dmem_access_unit_if.sv
// Data-memory bus bundle: single-beat request from the access unit, one-cycle ack from memory.
// Latency: none, wires only.
// Backpressure: the slave stretches a transaction by delaying BusAck; the master holds all request fields until then.
// Signals: BusReq/BusWE/BusAddr/BusByteEn/BusWData driven by master; BusAck/BusRData driven by slave.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              BusReq;
    logic              BusWE;
    logic [ADDR_W-1:0] BusAddr;
    logic [3:0]        BusByteEn;
    logic [31:0]       BusWData;
    logic              BusAck;
    logic [31:0]       BusRData;

    modport master (
        output BusReq, BusWE, BusAddr, BusByteEn, BusWData,
        input  BusAck, BusRData
    );

    modport slave (
        input  BusReq, BusWE, BusAddr, BusByteEn, BusWData,
        output BusAck, BusRData
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: issues one bus beat per lb/lbu/lh/lhu/lw/sb/sh/sw and aligns/extends load data.
// Latency: 2 stall cycles with a zero-wait slave, plus 1 per slave wait cycle; DMEMOut/LoadValid registered on the ack edge.
// Backpressure: MemStall freezes the pipeline from request until ack; it drops in DONE, where the held instruction is not re-issued.
// Ports: CLK, RESET_N (async active-low); pipeline side MemRead/MemWrite/MemSize/MemSigned/ALUout/StoreData in,
//        DMEMOut/LoadValid/MemStall out; bus side through dmem_access_unit_if.master.
// Optional: define MISALIGN_TRAP_EN to add AlignErr and trap misaligned half/word accesses without a bus cycle.
module dmem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    input  logic [ADDR_W-1:0] ALUout,
    input  logic [31:0]       StoreData,
    output logic [31:0]       DMEMOut,
    output logic              LoadValid,
    output logic              MemStall,
`ifdef MISALIGN_TRAP_EN
    output logic              AlignErr,
`endif
    dmem_access_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Attributes of the in-flight access needed to post-process read data.
    typedef struct packed {
        logic [1:0] size;
        logic       sgn;
        logic [1:0] lane;
        logic       is_load;
    } acc_t;

    state_t            state_q, state_d;
    acc_t              acc_q, acc_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [31:0]       dmem_out_q, dmem_out_d;
    logic              load_valid_q, load_valid_d;
`ifdef MISALIGN_TRAP_EN
    logic              align_err_q, align_err_d;
`endif

    logic        req;
    logic        misalign;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    assign req = MemRead | MemWrite;

    // Lane enables and replicated store data come straight from the live request.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = StoreData;
        misalign   = 1'b0;
        case (MemSize)
            2'b00: begin
                be_calc    = 4'b0001 << ALUout[1:0];
                wdata_calc = {4{StoreData[7:0]}};
            end
            2'b01: begin
                be_calc    = ALUout[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{StoreData[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = StoreData;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((MemSize == 2'b01) && ALUout[0]) ||
                   (MemSize[1] && (ALUout[1:0] != 2'b00));
`endif
    end

    // Little-endian lane pick from the captured address, then extend.
    always_comb begin
        rbyte    = 8'h00;
        case (acc_q.lane)
            2'd0:    rbyte = bus.BusRData[7:0];
            2'd1:    rbyte = bus.BusRData[15:8];
            2'd2:    rbyte = bus.BusRData[23:16];
            default: rbyte = bus.BusRData[31:24];
        endcase
        rhalf    = acc_q.lane[1] ? bus.BusRData[31:16] : bus.BusRData[15:0];
        load_ext = bus.BusRData;
        case (acc_q.size)
            2'b00:   load_ext = {{24{acc_q.sgn & rbyte[7]}}, rbyte};
            2'b01:   load_ext = {{16{acc_q.sgn & rhalf[15]}}, rhalf};
            default: load_ext = bus.BusRData;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        dmem_out_d   = dmem_out_q;
        load_valid_d = load_valid_q;
`ifdef MISALIGN_TRAP_EN
        align_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    // Write wins when both strobes are set, so no load result follows.
                    acc_d = '{size: MemSize, sgn: MemSigned, lane: ALUout[1:0],
                              is_load: MemRead & ~MemWrite};
                    if (misalign) begin
                        state_d = DONE;
`ifdef MISALIGN_TRAP_EN
                        align_err_d = 1'b1;
`endif
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {ALUout[ADDR_W-1:2], 2'b00};
                        bus_be_d    = be_calc;
                        bus_wdata_d = wdata_calc;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.BusAck) begin
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (acc_q.is_load) begin
                        dmem_out_d   = load_ext;
                        load_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // Instruction is still on the inputs here; ignore it and return.
                load_valid_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= '0;
            dmem_out_q   <= '0;
            load_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            align_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            dmem_out_q   <= dmem_out_d;
            load_valid_q <= load_valid_d;
`ifdef MISALIGN_TRAP_EN
            align_err_q  <= align_err_d;
`endif
        end
    end

    // Stall asserts in the request cycle itself so the EX/MEM register freezes immediately.
    assign MemStall      = RESET_N && (((state_q == IDLE) && req) || (state_q == ACCESS));
    assign DMEMOut       = dmem_out_q;
    assign LoadValid     = load_valid_q;
    assign bus.BusReq    = bus_req_q;
    assign bus.BusWE     = bus_we_q;
    assign bus.BusAddr   = bus_addr_q;
    assign bus.BusByteEn = bus_be_q;
    assign bus.BusWData  = bus_wdata_q;
`ifdef MISALIGN_TRAP_EN
    assign AlignErr      = align_err_q;
`endif

endmodule
